// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution-input sequencer.
//   seq_state_e  : sequencer FSM states
//   TUSER_*      : bit offsets of the fields inside m_axis_tuser
//   tuser_width  : total tuser width for a given kernel-index width
package conv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int TUSER_IS_FIRST    = 0;
    localparam int TUSER_IS_CIN_LAST = 1;
    localparam int TUSER_KW_IDX      = 2;

    function automatic int tuser_width(input int kw_w);
        return kw_w + TUSER_KW_IDX;
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// One level of the kw -> cin -> cols loop nest.
//   clear : synchronous return to 0 (wins over en)
//   en    : advance by one; wraps to 0 when count == max
//   max   : terminal value (loop bound minus one)
//   count : current index
//   last  : count is at its terminal value (carry into the next level when en)
module conv_loop_counter #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q, count_d;

    assign last  = (count_q == max);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_conv_sequencer.sv
// Front end of the convolution engine: takes one tile configuration, joins the
// pixel and weight AXI-Streams beat for beat and tags each beat with tlast and
// tuser = {kw_idx, is_cin_last, is_first} from the kw -> cin -> cols loop nest.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | cfg_ready high, waiting for a tile configuration
//   RUN   | joining streams; counters advance on every fired beat
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   cfg_valid/ready/kw/cin/cols   tile configuration handshake
//   s_pix_*, s_wgt_*         upstream pixel and weight streams
//   m_axis_*                 joined stream to the engine
//   done, busy               tile-complete pulse, RUN indicator
module axis_conv_sequencer
    import conv_seq_pkg::*;
#(
    parameter int COPIES     = 2,
    parameter int UNITS      = 4,
    parameter int GROUPS     = 1,
    parameter int MEMBERS    = 8,
    parameter int WORD_WIDTH = 8,
    parameter int KW_MAX     = 15,
    parameter int CIN_W      = 16,
    parameter int COLS_W     = 16,
    localparam int KW_W      = $clog2(KW_MAX + 1),
    localparam int PIX_W     = COPIES * UNITS * WORD_WIDTH,
    localparam int WGT_W     = COPIES * GROUPS * MEMBERS * WORD_WIDTH,
    localparam int TU_W      = tuser_width(KW_W)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [KW_W-1:0]   cfg_kw,
    input  logic [CIN_W-1:0]  cfg_cin,
    input  logic [COLS_W-1:0] cfg_cols,
    input  logic              s_pix_tvalid,
    output logic              s_pix_tready,
    input  logic [PIX_W-1:0]  s_pix_tdata,
    input  logic              s_wgt_tvalid,
    output logic              s_wgt_tready,
    input  logic [WGT_W-1:0]  s_wgt_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [PIX_W-1:0]  m_axis_tdata_pixels,
    output logic [WGT_W-1:0]  m_axis_tdata_weights,
    output logic              m_axis_tlast,
    output logic [TU_W-1:0]   m_axis_tuser,
    output logic              done,
    output logic              busy
);

    seq_state_e state_q, state_d;

    // Bounds are stored minus one so the counters compare against them directly.
    logic [KW_W-1:0]   kw_max_q;
    logic [CIN_W-1:0]  cin_max_q;
    logic [COLS_W-1:0] cols_max_q;

    logic [KW_W-1:0]   k_cnt;
    logic [CIN_W-1:0]  c_cnt;
    logic [COLS_W-1:0] col_cnt;
    logic              k_last, c_last, col_last;

    logic run, cfg_fire, cfg_zero, fire;

    assign run       = (state_q == RUN);
    assign cfg_ready = (state_q == IDLE);
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign cfg_zero  = (cfg_kw == '0) | (cfg_cin == '0) | (cfg_cols == '0);

    // Each ready depends only on the other stream's valid, so neither source
    // can be consumed without its partner and no valid waits on a ready.
    assign m_axis_tvalid = run & s_pix_tvalid & s_wgt_tvalid;
    assign s_pix_tready  = run & m_axis_tready & s_wgt_tvalid;
    assign s_wgt_tready  = run & m_axis_tready & s_pix_tvalid;
    assign fire          = m_axis_tvalid & m_axis_tready;

    assign m_axis_tdata_pixels  = s_pix_tdata;
    assign m_axis_tdata_weights = s_wgt_tdata;
    assign m_axis_tlast         = k_last & c_last;

    always_comb begin
        m_axis_tuser                                 = '0;
        m_axis_tuser[TUSER_IS_FIRST]                 = (k_cnt == '0) & (c_cnt == '0);
        m_axis_tuser[TUSER_IS_CIN_LAST]              = c_last;
        m_axis_tuser[TUSER_KW_IDX +: KW_W]           = k_cnt;
    end

    assign done = (state_q == DONE);
    assign busy = run;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    state_d = cfg_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire & k_last & c_last & col_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            kw_max_q   <= '0;
            cin_max_q  <= '0;
            cols_max_q <= '0;
        end else if (cfg_fire) begin
            kw_max_q   <= cfg_kw - KW_W'(1);
            cin_max_q  <= cfg_cin - CIN_W'(1);
            cols_max_q <= cfg_cols - COLS_W'(1);
        end
    end

    conv_loop_counter #(.W(KW_W)) u_k_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (cfg_fire),
        .en      (fire),
        .max     (kw_max_q),
        .count   (k_cnt),
        .last    (k_last)
    );

    conv_loop_counter #(.W(CIN_W)) u_c_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (cfg_fire),
        .en      (fire & k_last),
        .max     (cin_max_q),
        .count   (c_cnt),
        .last    (c_last)
    );

    conv_loop_counter #(.W(COLS_W)) u_col_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (cfg_fire),
        .en      (fire & k_last & c_last),
        .max     (cols_max_q),
        .count   (col_cnt),
        .last    (col_last)
    );

endmodule

// File: tb/tb_axis_conv_sequencer.sv
module tb_axis_conv_sequencer;

    localparam int KW_W  = 4;
    localparam int PIX_W = 64;
    localparam int WGT_W = 128;
    localparam int TU_W  = KW_W + 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [KW_W-1:0]   cfg_kw;
    logic [15:0]       cfg_cin;
    logic [15:0]       cfg_cols;
    logic              s_pix_tvalid;
    logic              s_pix_tready;
    logic [PIX_W-1:0]  s_pix_tdata;
    logic              s_wgt_tvalid;
    logic              s_wgt_tready;
    logic [WGT_W-1:0]  s_wgt_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [PIX_W-1:0]  m_axis_tdata_pixels;
    logic [WGT_W-1:0]  m_axis_tdata_weights;
    logic              m_axis_tlast;
    logic [TU_W-1:0]   m_axis_tuser;
    logic              done;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int k;
        bit cin_last;
        bit first;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    axis_conv_sequencer dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .cfg_kw               (cfg_kw),
        .cfg_cin              (cfg_cin),
        .cfg_cols             (cfg_cols),
        .s_pix_tvalid         (s_pix_tvalid),
        .s_pix_tready         (s_pix_tready),
        .s_pix_tdata          (s_pix_tdata),
        .s_wgt_tvalid         (s_wgt_tvalid),
        .s_wgt_tready         (s_wgt_tready),
        .s_wgt_tdata          (s_wgt_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tdata_pixels  (m_axis_tdata_pixels),
        .m_axis_tdata_weights (m_axis_tdata_weights),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tuser         (m_axis_tuser),
        .done                 (done),
        .busy                 (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the loop nest written out directly, innermost index is k.
    task automatic build_model(input int kw, input int cin, input int cols);
        exp_q.delete();
        if (kw == 0 || cin == 0 || cols == 0) return;
        for (int col = 0; col < cols; col++)
            for (int c = 0; c < cin; c++)
                for (int k = 0; k < kw; k++)
                    exp_q.push_back('{k, (c == cin - 1), (k == 0 && c == 0),
                                      (k == kw - 1 && c == cin - 1)});
    endtask

    // wv_alt: weight valid only on even cycles. stall_at: hold ready low for 5
    // cycles when that beat is presented. abort_at: reset when that beat is presented.
    task automatic run_tile(input int kw, input int cin, input int cols,
                            input int pv_pct, input int wv_pct, input int rd_pct,
                            input bit wv_alt, input int stall_at, input int abort_at);
        int total, beats, cyc, pcnt, wcnt, stall_left;
        logic [TU_W-1:0] exp_tu;
        build_model(kw, cin, cols);
        total = exp_q.size();
        beats = 0; cyc = 0; pcnt = 0; wcnt = 0; stall_left = 5;

        @(posedge aclk); #1;
        cfg_valid = 1'b1;
        cfg_kw    = KW_W'(kw);
        cfg_cin   = 16'(cin);
        cfg_cols  = 16'(cols);
        #4;
        chk("cfg_ready_idle", cfg_ready, 1'b1);
        chk("busy_idle", busy, 1'b0);
        @(posedge aclk); #1;
        cfg_valid = 1'b0;

        while (beats < total && cyc < 4000) begin
            s_pix_tvalid  = ($urandom_range(99) < pv_pct);
            s_wgt_tvalid  = wv_alt ? (cyc % 2 == 0) : ($urandom_range(99) < wv_pct);
            m_axis_tready = ($urandom_range(99) < rd_pct);
            if (stall_at >= 0 && beats == stall_at && stall_left > 0) begin
                s_pix_tvalid  = 1'b1;
                s_wgt_tvalid  = 1'b1;
                m_axis_tready = 1'b0;
                stall_left--;
            end
            s_pix_tdata = {$urandom, $urandom};
            s_wgt_tdata = {$urandom, $urandom, $urandom, $urandom};
            cfg_valid   = $urandom_range(1);
            cfg_kw      = KW_W'($urandom);
            cfg_cin     = 16'($urandom);
            cfg_cols    = 16'($urandom);
            #4;
            if (abort_at >= 0 && beats == abort_at) begin
                cfg_valid = 1'b0;
                aresetn   = 1'b0;
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_tvalid", m_axis_tvalid, 1'b0);
                chk("abort_cfg_ready", cfg_ready, 1'b1);
                chk("abort_done", done, 1'b0);
                s_pix_tvalid = 1'b0;
                s_wgt_tvalid = 1'b0;
                @(posedge aclk); #1;
                aresetn = 1'b1;
                return;
            end
            chk("run_busy", busy, 1'b1);
            chk("run_cfg_ready", cfg_ready, 1'b0);
            chk("run_done", done, 1'b0);
            chk("tvalid", m_axis_tvalid, s_pix_tvalid & s_wgt_tvalid);
            chk("pix_tready", s_pix_tready, m_axis_tready & s_wgt_tvalid);
            chk("wgt_tready", s_wgt_tready, m_axis_tready & s_pix_tvalid);
            if (s_pix_tvalid && s_wgt_tvalid) begin
                exp_tu = {KW_W'(exp_q[beats].k), exp_q[beats].cin_last, exp_q[beats].first};
                chk("tlast", m_axis_tlast, exp_q[beats].last);
                chk("tuser", m_axis_tuser, exp_tu);
                chk("pix_data", m_axis_tdata_pixels, s_pix_tdata);
                chk("wgt_data", m_axis_tdata_weights, s_wgt_tdata);
            end
            if (s_pix_tvalid && s_pix_tready) pcnt++;
            if (s_wgt_tvalid && s_wgt_tready) wcnt++;
            if (s_pix_tvalid && s_wgt_tvalid && m_axis_tready) beats++;
            @(posedge aclk); #1;
            cyc++;
        end
        s_pix_tvalid = 1'b0;
        s_wgt_tvalid = 1'b0;
        cfg_valid    = 1'b0;
        chk("beat_count", beats, total);
        chk("pix_consumed", pcnt, total);
        chk("wgt_consumed", wcnt, total);
        #4;
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_tvalid", m_axis_tvalid, 1'b0);
        chk("done_cfg_ready", cfg_ready, 1'b0);
        @(posedge aclk); #1;
        #4;
        chk("done_cleared", done, 1'b0);
        chk("cfg_ready_back", cfg_ready, 1'b1);
    endtask

    initial begin
        aresetn       = 1'b0;
        cfg_valid     = 1'b0;
        cfg_kw        = '0;
        cfg_cin       = '0;
        cfg_cols      = '0;
        s_pix_tvalid  = 1'b0;
        s_wgt_tvalid  = 1'b0;
        s_pix_tdata   = '0;
        s_wgt_tdata   = '0;
        m_axis_tready = 1'b0;
        #12;
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        s_pix_tvalid = 1'b1;
        s_wgt_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_pix_tready", s_pix_tready, 1'b0);
        s_pix_tvalid = 1'b0;
        s_wgt_tvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;

        run_tile(3, 2, 2, 100, 100, 100, 1'b0, -1, -1);
        run_tile(3, 2, 2, 100, 100, 100, 1'b1, -1, -1);
        run_tile(3, 2, 2, 100, 100, 100, 1'b0, 3, -1);
        run_tile(3, 0, 2, 100, 100, 100, 1'b0, -1, -1);
        run_tile(0, 4, 2, 100, 100, 100, 1'b0, -1, -1);
        run_tile(1, 1, 3, 100, 100, 100, 1'b0, -1, -1);
        run_tile(3, 2, 2, 100, 100, 100, 1'b0, -1, 4);
        run_tile(2, 1, 1, 100, 100, 100, 1'b0, -1, -1);
        run_tile(15, 2, 2, 70, 70, 70, 1'b0, -1, -1);
        run_tile(2, 16'hFFFF, 1, 100, 100, 100, 1'b0, -1, 6);
        run_tile(2, 1, 1, 100, 100, 100, 1'b0, -1, -1);

        for (int t = 0; t < 8; t++) begin
            run_tile(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
                     int'($urandom_range(1, 3)), int'($urandom_range(30, 100)),
                     int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                     1'b0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
